ph_frame_packer: RTL and testbench

Upstream feeder for the pulse-height cache. It packs the per-channel 16-bit pulse-height samples from the MAROC ADC front end into 32-bit words and stores each frame in a commit-on-complete FIFO. It then emits every complete frame as one contiguous AXI-stream burst terminated by `tlast`. The cache resets its write address whenever `tvalid` drops and toggles its ping-pong bank on `tlast`, so this block never emits a partial frame or a gapped burst, and always leaves at least one idle cycle between frames.

---
 rtl/ph_frame_packer.sv | 148 ++++++++++++++
 tb/tb_ph_frame_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ph_frame_packer.sv
// Packs 16-bit pulse-height samples into 32-bit words, buffers whole frames in a
// commit-on-complete FIFO and emits each committed frame as one gap-free AXI-stream burst.
module ph_frame_packer #(
    parameter int unsigned NCHAN   = 64,
    parameter int unsigned FIFO_AW = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        frame_start,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic        busy
);

    localparam int unsigned WORDS = NCHAN / 2;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP} r_state_t;

    w_state_t        w_state, w_state_nx;
    r_state_t        r_state, r_state_nx;

    logic [32:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, frames_ready, fr_nx, rd_addr;
    logic [CW-1:0]   word_cnt;
    logic            half;
    logic [15:0]     low_q;
    logic [32:0]     rd_word;

    logic sample_start, pair_done, fifo_full, word_last;
    logic wr_en, commit, overflow, abort_restart;
    logic handshake, frame_sent, load, busy_nx;

    // Write-side control decode
    always_comb begin
        sample_start  = sample_valid & frame_start;
        pair_done     = sample_valid & ~frame_start & (w_state == W_FILL) & half;
        fifo_full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
        word_last     = (word_cnt == CW'(WORDS - 1));
        wr_en         = pair_done & ~fifo_full;
        commit        = wr_en & word_last;
        overflow      = pair_done & fifo_full;
        abort_restart = sample_start & (w_state == W_FILL);
    end

    // Write FSM next state
    always_comb begin
        w_state_nx = w_state;
        if (sample_start)  w_state_nx = W_FILL;
        else if (overflow) w_state_nx = W_DISCARD;
        else if (commit)   w_state_nx = W_IDLE;
    end

    // Read FSM next state; the gap state chains straight into a waiting frame so
    // back-to-back frames are separated by a single idle cycle
    always_comb begin
        r_state_nx = r_state;
        unique case (r_state)
            R_IDLE:  if (frames_ready != '0) r_state_nx = R_BURST;
            R_BURST: if (frame_sent)         r_state_nx = R_GAP;
            R_GAP:   r_state_nx = (frames_ready != '0) ? R_BURST : R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Read-side control and frame bookkeeping
    always_comb begin
        handshake  = m_axis_tvalid & m_axis_tready;
        frame_sent = handshake & m_axis_tlast;
        load       = (r_state != R_BURST) && (r_state_nx == R_BURST);
        rd_addr    = load ? rd_ptr : rd_ptr + PW'(1);
        rd_word    = mem[rd_addr[FIFO_AW-1:0]];
        fr_nx      = frames_ready;
        if (commit && !frame_sent)      fr_nx = frames_ready + PW'(1);
        else if (!commit && frame_sent) fr_nx = frames_ready - PW'(1);
        busy_nx    = (w_state_nx == W_FILL) || (fr_nx != '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {word_last, sample_data, low_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            frames_ready  <= '0;
            word_cnt      <= '0;
            half          <= 1'b0;
            low_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            frame_count   <= '0;
            drop_count    <= '0;
            busy          <= 1'b0;
        end else begin
            w_state      <= w_state_nx;
            r_state      <= r_state_nx;
            frames_ready <= fr_nx;
            busy         <= busy_nx;

            if (sample_start) begin
                word_cnt <= '0;
                half     <= 1'b1;
                low_q    <= sample_data;
                if (w_state == W_FILL) wr_ptr <= commit_ptr;
            end else if (sample_valid && w_state == W_FILL) begin
                if (!half) begin
                    low_q <= sample_data;
                    half  <= 1'b1;
                end else begin
                    half <= 1'b0;
                    if (fifo_full) begin
                        wr_ptr <= commit_ptr;
                    end else begin
                        wr_ptr   <= wr_ptr + PW'(1);
                        word_cnt <= word_cnt + CW'(1);
                        if (word_last) commit_ptr <= wr_ptr + PW'(1);
                    end
                end
            end

            frame_count <= frame_count + 16'(commit);
            drop_count  <= drop_count + 16'(abort_restart | overflow);

            if (handshake) rd_ptr <= rd_ptr + PW'(1);
            if (load || (handshake && !m_axis_tlast)) begin
                m_axis_tlast <= rd_word[32];
                m_axis_tdata <= rd_word[31:0];
            end
            m_axis_tvalid <= (r_state_nx == R_BURST);
        end
    end

endmodule

// File: tb/tb_ph_frame_packer.sv
// Scoreboard bench for ph_frame_packer: expected words are queued as frames are
// driven and compared as the stream handshakes them.
module tb_ph_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        frame_start;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    bit          gap_chk  = 1'b0;

    ph_frame_packer #(.NCHAN(64), .FIFO_AW(7)) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_data(sample_data), .frame_start(frame_start),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .frame_count(frame_count), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stream monitor: pops the scoreboard on handshakes and checks burst shape
    bit prev_mid  = 1'b0;
    bit seen_last = 1'b0;
    int low_run   = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_mid  = 1'b0;
            seen_last = 1'b0;
            low_run   = 0;
        end else begin
            if (prev_mid && m_axis_tready) check_eq("burst_contig", 33'(m_axis_tvalid), 33'd1);
            if (m_axis_tvalid) begin
                if (gap_chk && seen_last) check_eq("frame_gap", 33'(low_run), 33'd1);
                seen_last = 1'b0;
                low_run   = 0;
            end else begin
                low_run++;
            end
            prev_mid = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_word", {m_axis_tlast, m_axis_tdata}, 33'h0);
                end else begin
                    check_eq("word", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
                end
                prev_mid  = !m_axis_tlast;
                seen_last = m_axis_tlast;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] d, input logic fs, input int gap);
        sample_valid = 1'b1;
        sample_data  = d;
        frame_start  = fs;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [15:0] base, input int nsamp, input int gap, input bit push);
        if (push) begin
            for (int w = 0; w < nsamp / 2; w++)
                exp_q.push_back({(w == nsamp / 2 - 1), 16'(base + 16'(2 * w + 1)), 16'(base + 16'(2 * w))});
        end
        for (int i = 0; i < nsamp; i++) send_sample(16'(base + 16'(i)), (i == 0), gap);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", 33'(exp_q.size()), 33'd0);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_data = '0; frame_start = 1'b0; m_axis_tready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_tvalid", 33'(m_axis_tvalid), 33'd0);
        check_eq("rst_tdata", 33'(m_axis_tdata), 33'd0);
        check_eq("rst_tlast", 33'(m_axis_tlast), 33'd0);
        check_eq("rst_frames", 33'(frame_count), 33'd0);
        check_eq("rst_drops", 33'(drop_count), 33'd0);
        check_eq("rst_busy", 33'(busy), 33'd0);

        // Single frame with latency check
        send_frame(16'h0000, 64, 0, 1'b1);
        check_eq("lat_edge_k", 33'(m_axis_tvalid), 33'd0);
        tick();
        check_eq("lat_edge_k1", 33'(m_axis_tvalid), 33'd1);
        check_eq("word0", {m_axis_tlast, m_axis_tdata}, 33'h0_0001_0000);
        wait_drain(100);
        check_eq("single_frames", 33'(frame_count), 33'd1);
        check_eq("single_busy", 33'(busy), 33'd0);

        // Gapped input
        do_reset();
        send_frame(16'h0000, 64, 2, 1'b1);
        wait_drain(100);
        check_eq("gapped_frames", 33'(frame_count), 33'd1);

        // Back-to-back frames
        do_reset();
        send_frame(16'h1000, 64, 0, 1'b1);
        send_frame(16'h2000, 64, 0, 1'b1);
        wait_drain(100);
        check_eq("b2b_frames", 33'(frame_count), 33'd2);

        // Restart mid-frame
        do_reset();
        send_frame(16'h3000, 40, 0, 1'b0);
        send_frame(16'h4000, 64, 0, 1'b1);
        wait_drain(100);
        check_eq("restart_drops", 33'(drop_count), 33'd1);
        check_eq("restart_frames", 33'(frame_count), 33'd1);

        // Overflow with the stream stalled, then release
        do_reset();
        m_axis_tready = 1'b0;
        for (int f = 0; f < 5; f++) send_frame(16'(16'h0100 * (f + 1)), 64, 0, (f < 4));
        check_eq("ovf_frames", 33'(frame_count), 33'd4);
        check_eq("ovf_drops", 33'(drop_count), 33'd1);
        check_eq("ovf_busy", 33'(busy), 33'd1);
        check_eq("ovf_hold", {m_axis_tvalid, m_axis_tdata}, 33'h1_0101_0100);
        gap_chk = 1'b1;
        m_axis_tready = 1'b1;
        wait_drain(300);
        gap_chk = 1'b0;
        check_eq("ovf_idle_busy", 33'(busy), 33'd0);

        // Reset in the middle of a burst
        do_reset();
        send_frame(16'h5000, 64, 0, 1'b1);
        begin
            int n = 0;
            while (exp_q.size() > 20 && n < 100) begin
                tick();
                n++;
            end
        end
        check_eq("midburst_valid", 33'(m_axis_tvalid), 33'd1);
        do_reset();
        check_eq("post_rst_tvalid", 33'(m_axis_tvalid), 33'd0);
        check_eq("post_rst_frames", 33'(frame_count), 33'd0);
        check_eq("post_rst_drops", 33'(drop_count), 33'd0);
        send_frame(16'h6000, 64, 0, 1'b1);
        wait_drain(100);
        check_eq("after_rst_frames", 33'(frame_count), 33'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
